// File: rtl/clk_div_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi_pkg
// Description : Shared constants and types for the multi-channel clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_multi_pkg;

    // Default geometry of the divider
    localparam int DEF_WIDTH     = 20;
    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_HALF      = 500000;

    // Common half-period rates (clkin cycles) for typical consumers
    localparam int KBD_HALF      = 500000;
    localparam int DISP_HALF     = 50000;
    localparam int DEBOUNCE_HALF = 250000;

    // Where a divisor update lands in a given cycle
    typedef enum logic [1:0] {
        UPD_HOLD      = 2'd0,  // no change to divisor state
        UPD_STASH     = 2'd1,  // write parked in pend_half until terminal count
        UPD_LOAD_WR   = 2'd2,  // written value goes straight to active_half
        UPD_LOAD_PEND = 2'd3   // parked value promoted to active_half
    } upd_e;

endpackage
`default_nettype wire

// File: rtl/clk_div_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi_if
// Description : Control/status bundle of the multi-channel clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_multi_if
    import clk_div_multi_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH  = DEF_WIDTH
);
    logic [NUM_CH-1:0]       en;
    logic                    sync;
    logic [NUM_CH-1:0]       div_wr;
    logic [NUM_CH*WIDTH-1:0] div_in;
    logic [NUM_CH-1:0]       clkout;
    logic [NUM_CH-1:0]       tick;

    // Controller side drives the requests, observes the divided outputs
    modport master (
        output en, sync, div_wr, div_in,
        input  clkout, tick
    );

    // Divider side
    modport slave (
        input  en, sync, div_wr, div_in,
        output clkout, tick
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_multi_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel: half-period counter, divisor staging,
//               registered square-wave output and toggle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_multi_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             en_i,
    input  wire logic             sync_i,
    input  wire logic             div_wr_i,
    input  wire logic [WIDTH-1:0] div_in_i,
    output logic                  clkout_o,
    output logic                  tick_o
);
    localparam logic [WIDTH-1:0] C_RST_HALF = WIDTH'(DEFAULT_HALF);
    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pend_q,   pend_d;
    logic             pvld_q,   pvld_d;
    logic             clkout_q, clkout_d;
    logic             tick_q,   tick_d;

    logic [WIDTH-1:0] w_eff;
    logic             w_term;
    upd_e             w_upd;

    // A programmed half-period of 0 behaves as 1. The terminal test uses >=
    // so a divisor shrunk during a pause cannot leave cnt stranded above it.
    assign w_eff  = (active_q == '0) ? C_ONE : active_q;
    assign w_term = en_i && (cnt_q >= (w_eff - C_ONE));

    // Divisor staging: new values only reach active_half when cnt restarts
    // (sync or terminal count) or while the channel is paused.
    always_comb begin
        w_upd = UPD_HOLD;
        if (sync_i || !en_i || w_term) begin
            if (div_wr_i)
                w_upd = UPD_LOAD_WR;
            else if (pvld_q && (sync_i || w_term))
                w_upd = UPD_LOAD_PEND;
        end else if (div_wr_i) begin
            w_upd = UPD_STASH;
        end
    end

    // Next-state for counter, output and divisor registers
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        pend_d   = pend_q;
        pvld_d   = pvld_q;
        clkout_d = clkout_q;
        tick_d   = 1'b0;

        if (sync_i) begin
            cnt_d    = '0;
            clkout_d = 1'b0;
        end else if (w_term) begin
            cnt_d    = '0;
            clkout_d = ~clkout_q;
            tick_d   = 1'b1;
        end else if (en_i) begin
            cnt_d    = cnt_q + C_ONE;
        end

        case (w_upd)
            UPD_STASH: begin
                pend_d = div_in_i;
                pvld_d = 1'b1;
            end
            UPD_LOAD_WR: begin
                active_d = div_in_i;
                pvld_d   = 1'b0;
            end
            UPD_LOAD_PEND: begin
                active_d = pend_q;
                pvld_d   = 1'b0;
            end
            default: ;
        endcase
    end

    // State registers; reset overrides every other input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            active_q <= C_RST_HALF;
            pend_q   <= '0;
            pvld_q   <= 1'b0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pvld_q   <= pvld_d;
            clkout_q <= clkout_d;
            tick_q   <= tick_d;
        end
    end

    assign clkout_o = clkout_q;
    assign tick_o   = tick_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi
// Description : NUM_CH independent programmable clock dividers with tick
//               strobes and a shared phase-realign input.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  wire logic       clkin,
    input  wire logic       rst,
    clk_div_multi_if.slave  bus
);

    // One channel per output; sync and rst fan out to all of them
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            clk_div_chan #(
                .WIDTH        (WIDTH),
                .DEFAULT_HALF (DEFAULT_HALF)
            ) u_chan (
                .clk_i    (clkin),
                .rst_i    (rst),
                .en_i     (bus.en[i]),
                .sync_i   (bus.sync),
                .div_wr_i (bus.div_wr[i]),
                .div_in_i (bus.div_in[i*WIDTH +: WIDTH]),
                .clkout_o (bus.clkout[i]),
                .tick_o   (bus.tick[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_multi
// Description : Directed self-checking bench for clk_div_multi (2 channels,
//               reset half-period 4). Observed vector is {clkout[1:0],tick[1:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;
    localparam int W = 20;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    clk_div_multi_if #(.NUM_CH(2), .WIDTH(W)) bus ();

    clk_div_multi #(
        .WIDTH        (W),
        .NUM_CH       (2),
        .DEFAULT_HALF (4)
    ) dut (
        .clkin (clk),
        .rst   (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       r;
        logic       s;
        logic [1:0] en;
        logic [1:0] wr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] e;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic [1:0] en,
                                input logic [1:0] wr, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [3:0] e);
        vec_t v;
        v.r = r; v.s = s; v.en = en; v.wr = wr; v.d0 = d0; v.d1 = d1; v.e = e;
        return v;
    endfunction

    // Apply one vector's inputs (called on a negedge)
    task automatic drive(input vec_t v);
        rst        = v.r;
        bus.sync   = v.s;
        bus.en     = v.en;
        bus.div_wr = v.wr;
        bus.div_in = {12'd0, v.d1, 12'd0, v.d0};
    endtask

    task automatic test_reset();
        drive(mk(1, 0, 2'b11, 2'b00, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.clkout, bus.tick} !== 4'h0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %b want 0000", k, {bus.clkout, bus.tick});
            end
        end
    endtask

    // Default half-period 4 on ch0, ch1 disabled
    task automatic test_default_rate();
        logic [3:0] exp;
        drive(mk(0, 0, 2'b01, 2'b00, 0, 0, 0));
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp = {2'b00, 2'b00};
            exp[2] = ((k / 4) % 2) == 1;
            exp[0] = (k % 4) == 0;
            n_tests++;
            if ({bus.clkout, bus.tick} !== exp) begin
                n_fail++;
                $display("FAIL default_rate step %0d: got %b want %b", k, {bus.clkout, bus.tick}, exp);
            end
        end
    endtask

    // Write while running is deferred to the next terminal count
    task automatic test_pending_write();
        vec_t v [10];
        v[0] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h0);
        v[1] = mk(0, 0, 2'b01, 2'b01, 2, 0, 4'h0);
        v[2] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h0);
        v[3] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h5);
        v[4] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h4);
        v[5] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h1);
        v[6] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h0);
        v[7] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h5);
        v[8] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h4);
        v[9] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h1);
        foreach (v[s]) begin
            drive(v[s]);
            @(negedge clk);
            n_tests++;
            if ({bus.clkout, bus.tick} !== v[s].e) begin
                n_fail++;
                $display("FAIL pending_write step %0d: got %b want %b", s, {bus.clkout, bus.tick}, v[s].e);
            end
        end
    endtask

    // Write on the terminal cycle applies immediately; half 0 behaves as 1
    task automatic test_write_on_term();
        vec_t v [12];
        v[0]  = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h0);
        v[1]  = mk(0, 0, 2'b01, 2'b01, 3, 0, 4'h5);
        v[2]  = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h4);
        v[3]  = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h4);
        v[4]  = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h1);
        v[5]  = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h0);
        v[6]  = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h0);
        v[7]  = mk(0, 0, 2'b01, 2'b01, 0, 0, 4'h5);
        v[8]  = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h1);
        v[9]  = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h5);
        v[10] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h1);
        v[11] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h5);
        foreach (v[s]) begin
            drive(v[s]);
            @(negedge clk);
            n_tests++;
            if ({bus.clkout, bus.tick} !== v[s].e) begin
                n_fail++;
                $display("FAIL write_on_term step %0d: got %b want %b", s, {bus.clkout, bus.tick}, v[s].e);
            end
        end
    endtask

    // Paused write of 4, run to cnt=2, hold 10 cycles, resume
    task automatic test_pause();
        vec_t v [15];
        v[0] = mk(0, 0, 2'b00, 2'b01, 4, 0, 4'h4);
        v[1] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h4);
        v[2] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h4);
        for (int k = 3; k < 13; k++) v[k] = mk(0, 0, 2'b00, 2'b00, 0, 0, 4'h4);
        v[13] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h4);
        v[14] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h1);
        foreach (v[s]) begin
            drive(v[s]);
            @(negedge clk);
            n_tests++;
            if ({bus.clkout, bus.tick} !== v[s].e) begin
                n_fail++;
                $display("FAIL pause step %0d: got %b want %b", s, {bus.clkout, bus.tick}, v[s].e);
            end
        end
    endtask

    // Pause at cnt=3, shrink to 2 while paused: term on first enabled cycle
    task automatic test_shrink_paused();
        vec_t v [7];
        v[0] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h0);
        v[1] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h0);
        v[2] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h0);
        v[3] = mk(0, 0, 2'b00, 2'b01, 2, 0, 4'h0);
        v[4] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h5);
        v[5] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h4);
        v[6] = mk(0, 0, 2'b01, 2'b00, 0, 0, 4'h1);
        foreach (v[s]) begin
            drive(v[s]);
            @(negedge clk);
            n_tests++;
            if ({bus.clkout, bus.tick} !== v[s].e) begin
                n_fail++;
                $display("FAIL shrink_paused step %0d: got %b want %b", s, {bus.clkout, bus.tick}, v[s].e);
            end
        end
    endtask

    // Halves 3/5 via sync+write, mid-count sync, mid-period rst, pending on sync
    task automatic test_sync_rst();
        vec_t v [20];
        v[0]  = mk(0, 1, 2'b00, 2'b11, 3, 5, 4'h0);
        v[1]  = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h0);
        v[2]  = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h0);
        v[3]  = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h5);
        v[4]  = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h4);
        v[5]  = mk(0, 1, 2'b11, 2'b00, 0, 0, 4'h0);
        v[6]  = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h0);
        v[7]  = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h0);
        v[8]  = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h5);
        v[9]  = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h4);
        v[10] = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'hE);
        v[11] = mk(1, 0, 2'b11, 2'b00, 0, 0, 4'h0);
        v[12] = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h0);
        v[13] = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h0);
        v[14] = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h0);
        v[15] = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'hF);
        v[16] = mk(0, 0, 2'b11, 2'b10, 0, 2, 4'hC);
        v[17] = mk(0, 1, 2'b11, 2'b00, 0, 0, 4'h0);
        v[18] = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'h0);
        v[19] = mk(0, 0, 2'b11, 2'b00, 0, 0, 4'hA);
        foreach (v[s]) begin
            drive(v[s]);
            @(negedge clk);
            n_tests++;
            if ({bus.clkout, bus.tick} !== v[s].e) begin
                n_fail++;
                $display("FAIL sync_rst step %0d: got %b want %b", s, {bus.clkout, bus.tick}, v[s].e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_pending_write();
        test_write_on_term();
        test_pause();
        test_shrink_paused();
        test_sync_rst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
